// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-style floating-point adder/subtractor (align, add, normalize, round).
// Define FPADD_ROUND_EN for round-to-nearest-even; otherwise ROUND truncates.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a_in,
  input  logic [EXP_W+MAN_W:0]   b_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int D  = MAN_W + 5;
  localparam int CW = $clog2(MAN_W + 4);
  localparam logic [EXP_W-1:0] EXP_MAX   = {EXP_W{1'b1}};
  localparam logic [EXP_W:0]   EXP_ONE   = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    SHIFT_LIM = CW'(MAN_W + 3);

  typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ADD, NORM, ROUND, FIN} state_t;

  state_t           state_r, state_s;
  logic [W-1:0]     a_cap_r, a_cap_s, b_cap_r, b_cap_s;
  logic             op_r, op_s;
  logic             sign_r, sign_s, eff_sub_r, eff_sub_s, zflush_r, zflush_s;
  logic [EXP_W:0]   exp_r, exp_s;
  logic [EXP_W-1:0] diff_r, diff_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [D-1:0]     ma_r, ma_s, mb_r, mb_s;
  logic [W-1:0]     pack_r, pack_s, result_r, result_s;
  logic             povf_r, povf_s, ovf_r, ovf_s, done_r, done_s, busy_r, busy_s;

  logic             sa_s, sb_s, a_big_s, inc_s;
  logic [EXP_W-1:0] ea_s, eb_s;
  logic [MAN_W-1:0] fa_s, fb_s, man_fin_s;
  logic [MAN_W+1:0] rnd_s;
  logic [EXP_W:0]   exp_fin_s;

  // Right shift by one that folds the bits falling off into the sticky position.
  function automatic logic [D-1:0] shr_sticky(input logic [D-1:0] v);
    shr_sticky = {1'b0, v[D-1:2], v[1] | v[0]};
  endfunction

  assign sa_s    = a_cap_r[W-1];
  assign ea_s    = a_cap_r[W-2:MAN_W];
  assign fa_s    = a_cap_r[MAN_W-1:0];
  assign sb_s    = b_cap_r[W-1] ^ op_r;
  assign eb_s    = b_cap_r[W-2:MAN_W];
  assign fb_s    = b_cap_r[MAN_W-1:0];
  assign a_big_s = ({ea_s, fa_s} >= {eb_s, fb_s});

`ifdef FPADD_ROUND_EN
  logic g_s, rs_s, lsb_s;
  assign lsb_s = ma_r[3];
  assign g_s   = ma_r[2];
  assign rs_s  = ma_r[1] | ma_r[0];
  assign inc_s = g_s & (rs_s | lsb_s);
`else
  assign inc_s = 1'b0;
`endif

  // Datapath layout: {carry, hidden, mantissa, guard, round, sticky}.
  assign rnd_s     = {1'b0, ma_r[D-2:3]} + {{(MAN_W+1){1'b0}}, inc_s};
  assign exp_fin_s = exp_r + {{EXP_W{1'b0}}, rnd_s[MAN_W+1]};
  assign man_fin_s = rnd_s[MAN_W+1] ? rnd_s[MAN_W:1] : rnd_s[MAN_W-1:0];

  // Next-state and datapath update for each FSM phase.
  always_comb begin
    state_s   = state_r;
    a_cap_s   = a_cap_r;
    b_cap_s   = b_cap_r;
    op_s      = op_r;
    sign_s    = sign_r;
    eff_sub_s = eff_sub_r;
    zflush_s  = zflush_r;
    exp_s     = exp_r;
    diff_s    = diff_r;
    cnt_s     = cnt_r;
    ma_s      = ma_r;
    mb_s      = mb_r;
    pack_s    = pack_r;
    povf_s    = povf_r;
    result_s  = result_r;
    ovf_s     = ovf_r;
    done_s    = 1'b0;
    busy_s    = busy_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_cap_s = a_in;
          b_cap_s = b_in;
          op_s    = op;
          busy_s  = 1'b1;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        povf_s    = 1'b0;
        zflush_s  = 1'b0;
        cnt_s     = {CW{1'b0}};
        eff_sub_s = sa_s ^ sb_s;
        if (ea_s == EXP_MAX) begin
          pack_s  = a_cap_r;
          state_s = FIN;
        end else if (eb_s == EXP_MAX) begin
          pack_s  = {sb_s, eb_s, fb_s};
          state_s = FIN;
        end else if ((ea_s == {EXP_W{1'b0}}) && (eb_s == {EXP_W{1'b0}})) begin
          pack_s  = {sa_s & sb_s, {(W-1){1'b0}}};
          state_s = FIN;
        end else if (ea_s == {EXP_W{1'b0}}) begin
          pack_s  = {sb_s, eb_s, fb_s};
          state_s = FIN;
        end else if (eb_s == {EXP_W{1'b0}}) begin
          pack_s  = a_cap_r;
          state_s = FIN;
        end else if (a_big_s) begin
          sign_s  = sa_s;
          exp_s   = {1'b0, ea_s};
          diff_s  = ea_s - eb_s;
          ma_s    = {2'b01, fa_s, 3'b000};
          mb_s    = {2'b01, fb_s, 3'b000};
          state_s = ALIGN;
        end else begin
          sign_s  = sb_s;
          exp_s   = {1'b0, eb_s};
          diff_s  = eb_s - ea_s;
          ma_s    = {2'b01, fb_s, 3'b000};
          mb_s    = {2'b01, fa_s, 3'b000};
          state_s = ALIGN;
        end
      end
      ALIGN: begin
        if ((diff_r == {EXP_W{1'b0}}) || (cnt_r == SHIFT_LIM)) begin
          state_s = ADD;
        end else begin
          mb_s   = shr_sticky(mb_r);
          diff_s = diff_r - {{(EXP_W-1){1'b0}}, 1'b1};
          cnt_s  = cnt_r + CNT_ONE;
        end
      end
      ADD: begin
        ma_s    = eff_sub_r ? (ma_r - mb_r) : (ma_r + mb_r);
        state_s = NORM;
      end
      NORM: begin
        if (ma_r[D-1]) begin
          ma_s    = shr_sticky(ma_r);
          exp_s   = exp_r + EXP_ONE;
          state_s = ROUND;
        end else if (ma_r[D-2]) begin
          state_s = ROUND;
        end else if (ma_r == {D{1'b0}}) begin
          sign_s   = 1'b0;
          zflush_s = 1'b1;
          state_s  = ROUND;
        end else if (exp_r <= EXP_ONE) begin
          zflush_s = 1'b1;
          state_s  = ROUND;
        end else begin
          ma_s  = {ma_r[D-2:0], 1'b0};
          exp_s = exp_r - EXP_ONE;
        end
      end
      ROUND: begin
        if (zflush_r) begin
          pack_s = {sign_r, {(W-1){1'b0}}};
          povf_s = 1'b0;
        end else if (exp_fin_s >= {1'b0, EXP_MAX}) begin
          pack_s = {sign_r, EXP_MAX, {MAN_W{1'b0}}};
          povf_s = 1'b1;
        end else begin
          pack_s = {sign_r, exp_fin_s[EXP_W-1:0], man_fin_s};
          povf_s = 1'b0;
        end
        state_s = FIN;
      end
      FIN: begin
        result_s = pack_r;
        ovf_s    = povf_r;
        done_s   = 1'b1;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Register bank; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      a_cap_r   <= {W{1'b0}};
      b_cap_r   <= {W{1'b0}};
      op_r      <= 1'b0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      zflush_r  <= 1'b0;
      exp_r     <= {(EXP_W+1){1'b0}};
      diff_r    <= {EXP_W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      ma_r      <= {D{1'b0}};
      mb_r      <= {D{1'b0}};
      pack_r    <= {W{1'b0}};
      povf_r    <= 1'b0;
      result_r  <= {W{1'b0}};
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_cap_r   <= a_cap_s;
      b_cap_r   <= b_cap_s;
      op_r      <= op_s;
      sign_r    <= sign_s;
      eff_sub_r <= eff_sub_s;
      zflush_r  <= zflush_s;
      exp_r     <= exp_s;
      diff_r    <= diff_s;
      cnt_r     <= cnt_s;
      ma_r      <= ma_s;
      mb_r      <= mb_s;
      pack_r    <= pack_s;
      povf_r    <= povf_s;
      result_r  <= result_s;
      ovf_r     <= ovf_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign ovf    = ovf_r;

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width (legal 4..11).
REQ-002 The block SHALL have parameter MAN_W, default 23, stored mantissa field width (legal 4..52).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 The block SHALL have port op  input  1  0 = A+B, 1 = A-B; captured with operands.
REQ-007 The block SHALL have ports a_in, b_in  input  1+EXP_W+MAN_W each  IEEE-style operands {sign, exp, man}.
REQ-008 The block SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 The block SHALL have port result  output  1+EXP_W+MAN_W  sum/difference; held until the next done.
REQ-011 The block SHALL have port ovf  output  1  exponent overflow; valid with done, held with result.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, ALIGN, ADD, NORM, ROUND, FIN; IDLE->LOAD on start=1, otherwise stay in IDLE.
REQ-013 LOAD SHALL capture the operands, invert b sign when op=1, and swap operands so the larger magnitude is in A; it SHALL last 1 cycle.
REQ-014 ALIGN SHALL right-shift the B mantissa (hidden bit included) 1 bit per cycle, with guard, round, and sticky bits; it SHALL exit when the exponent difference is consumed or after MAN_W+3 shifts, whichever is first.
REQ-015 ADD SHALL add or subtract the mantissas per effective sign in 1 cycle, on a MAN_W+5 bit datapath.
REQ-016 NORM SHALL right-shift once on carry-out, otherwise left-shift 1 bit per cycle until the hidden bit = 1; the exponent SHALL be adjusted per shift.
REQ-017 ROUND SHALL take 1 cycle; FIN SHALL assert done for 1 cycle, deassert busy, and return to IDLE.
REQ-018 Latency from the start-sampled edge to done SHALL be at most 2*MAN_W+10 cycles; for equal exponents without cancellation it SHALL be exactly 6 cycles.
REQ-019 start while busy=1 SHALL be ignored.
REQ-020 Exponent field 0 (zero or denormal) SHALL be treated as signed zero; zero plus X SHALL return X unchanged.
REQ-021 An exact-zero mantissa sum SHALL return +0 with exponent 0.
REQ-022 Exponent reaching all-ones SHALL return signed infinity (exp all-ones, man 0) with ovf=1.
REQ-023 Exponent underflow during NORM SHALL flush the result to signed zero, with ovf=0.
REQ-024 An operand with exponent all-ones SHALL be passed through as the result, with no NaN/Inf arithmetic.

Reset
REQ-025 rst=0 SHALL force IDLE immediately, independent of clk.
REQ-026 Reset SHALL clear result, ovf, done, and busy to 0.
REQ-027 rst=0 mid-operation SHALL abort the operation with no done pulse.
REQ-028 The first start SHALL be accepted on the first clk edge after rst rises.

Configuration
REQ-029 With FPADD_ROUND_EN defined, ROUND SHALL perform round-to-nearest-even using guard, round, and sticky bits.
REQ-030 With FPADD_ROUND_EN defined, mantissa overflow from rounding SHALL increment the exponent, which may set ovf per REQ-022.
REQ-031 With FPADD_ROUND_EN undefined, ROUND SHALL truncate (no increment); the state and its 1-cycle latency SHALL be retained.

Verification
REQ-032 The bench SHALL apply defaults, op=0, a=0x3FE00000, b=0x405CCCCD -> result=0x40A66666 (tie case, both configs), ovf=0.
REQ-033 The bench SHALL apply op=1, a=0x3F800000, b=0x3F800000 -> result=0x00000000, done after the NORM cancellation path.
REQ-034 The bench SHALL apply op=0, a=b=0x7F7FFFFF -> result=0x7F800000, ovf=1.
REQ-035 The bench SHALL apply op=0, a=0x3F800000, b=0x33C00000 -> 0x3F800001 with FPADD_ROUND_EN, 0x3F800000 without.
REQ-036 The bench SHALL drop rst low during ALIGN -> busy=0 and result=0 immediately, no done; then start with a=b=0x3F800000 -> result=0x40000000.
REQ-037 The bench SHALL pulse start again while busy=1 -> ignored, exactly one done, and result unaffected by the second operands.
